// File: rtl/video_ctrl_pkg.sv
// Shared types and constants for the video mode controller.
// Mode codes, field widths and FSM state encoding.
package video_ctrl_pkg;

  localparam int MODE_W = 2;
  localparam int TH_W   = 8;

  localparam logic [MODE_W-1:0] MODE_RGB  = 2'd0;
  localparam logic [MODE_W-1:0] MODE_GRAY = 2'd1;
  localparam logic [MODE_W-1:0] MODE_BIN  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_COMMIT  = 2'd2
  } state_t;

  function automatic logic [MODE_W-1:0] next_mode(
    input logic [MODE_W-1:0] m
  );
    case (m)
      MODE_RGB:  return MODE_GRAY;
      MODE_GRAY: return MODE_BIN;
      default:   return MODE_RGB;
    endcase
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Single-key synchroniser, debouncer and press detector.
// Emits one 1-cycle pulse per accepted 0->1 level change.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic press
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          ff1;
  logic          ff2;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  // Sync, count stable differing cycles, flip level, detect rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      ff1     <= 1'b0;
      ff2     <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      press   <= 1'b0;
      cnt     <= '0;
    end else begin
      ff1     <= key_raw;
      ff2     <= ff1;
      level_d <= level;
      press   <= level & ~level_d;
      if (ff2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= ff2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/video_mode_ctrl.sv
// Operator-control sequencer for the pixel stage.
// Shadows key-driven settings and commits them on frame edges.
module video_mode_ctrl
  import video_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TH_RESET        = 100,
  parameter int TH_STEP         = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] key,
  input  logic       i_vs,
  output logic [1:0] mode,
  output logic [7:0] threshold,
  output logic       cfg_update,
  output logic       pending
);

  localparam logic [TH_W-1:0] TH_RST = TH_W'(TH_RESET);
  localparam logic [TH_W:0]   STEP9  = (TH_W + 1)'(TH_STEP);

  logic [2:0]        press;
  logic [MODE_W-1:0] sh_mode;
  logic [TH_W-1:0]   sh_th;
  logic [MODE_W-1:0] sh_mode_nxt;
  logic [TH_W-1:0]   sh_th_nxt;
  logic [MODE_W-1:0] snap_mode;
  logic [TH_W-1:0]   snap_th;
  logic [TH_W:0]     th_up;
  logic [TH_W:0]     th_dn;
  logic              vs_d;
  logic              vs_edge;
  logic              diff_act;
  logic              diff_snap;
  state_t            state;
  state_t            state_nxt;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_db
      key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
        .clk    (clk),
        .rst    (rst),
        .key_raw(key[gi]),
        .press  (press[gi])
      );
    end
  endgenerate

  assign th_up   = {1'b0, sh_th} + STEP9;
  assign th_dn   = {1'b0, sh_th} - STEP9;
  assign vs_edge = i_vs & ~vs_d;

  assign diff_act  = {sh_mode, sh_th} != {mode, threshold};
  assign diff_snap = {sh_mode, sh_th} != {snap_mode, snap_th};

  // Next shadow values from this cycle's press pulses.
  always_comb begin
    sh_mode_nxt = sh_mode;
    sh_th_nxt   = sh_th;
    if (press[0]) sh_mode_nxt = next_mode(sh_mode);
    if (press[1] & ~press[2]) begin
      sh_th_nxt = th_up[TH_W] ? '1 : th_up[TH_W-1:0];
    end else if (press[2] & ~press[1]) begin
      sh_th_nxt = th_dn[TH_W] ? '0 : th_dn[TH_W-1:0];
    end
  end

  // Commit FSM next state.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (diff_act) state_nxt = ST_PENDING;
      end
      ST_PENDING: begin
        if (!diff_act)    state_nxt = ST_IDLE;
        else if (vs_edge) state_nxt = ST_COMMIT;
      end
      ST_COMMIT: begin
        state_nxt = diff_snap ? ST_PENDING : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, shadow, snapshot and active registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      vs_d       <= 1'b0;
      sh_mode    <= MODE_RGB;
      sh_th      <= TH_RST;
      snap_mode  <= MODE_RGB;
      snap_th    <= TH_RST;
      mode       <= MODE_RGB;
      threshold  <= TH_RST;
      cfg_update <= 1'b0;
      pending    <= 1'b0;
    end else begin
      state      <= state_nxt;
      vs_d       <= i_vs;
      sh_mode    <= sh_mode_nxt;
      sh_th      <= sh_th_nxt;
      cfg_update <= (state == ST_COMMIT);
      pending    <= (state_nxt != ST_IDLE) &
                    (state != ST_COMMIT);
      if (state == ST_PENDING && vs_edge) begin
        snap_mode <= sh_mode;
        snap_th   <= sh_th;
      end
      if (state == ST_COMMIT) begin
        mode      <= snap_mode;
        threshold <= snap_th;
      end
    end
  end

endmodule
